// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Byte-serial sequencer for the shared memory port, arbitrating
//            between instruction fetch and the load/store buffer.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int         FETCH_BYTES = 4,
    parameter logic [1:0] IO_SEL      = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] C_FETCH_N = 3'(FETCH_BYTES);

    state_t      r_state;
    logic        r_last_ls;
    logic        r_cur_ls;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [2:0]  r_n;
    logic [2:0]  r_cnt;

    logic        w_if_v;
    logic        w_ls_v;
    logic        w_pick_ls;
    logic        w_grant_stall;
    logic        w_io_stall;
    logic [2:0]  w_ls_n;
    logic [1:0]  w_bidx;
    logic [31:0] w_rd_word;

    always_comb begin
        w_if_v        = if_req & ~flush;
        w_ls_v        = ls_req;
        // On a conflict the requester that did not win last time goes first.
        w_pick_ls     = w_ls_v & (~w_if_v | ~r_last_ls);
        w_grant_stall = (ls_addr[17:16] == IO_SEL) & io_buffer_full;
        w_io_stall    = (r_addr[17:16] == IO_SEL) & io_buffer_full;
        case (ls_size)
            2'b00:   w_ls_n = 3'd1;
            2'b01:   w_ls_n = 3'd2;
            default: w_ls_n = 3'd4;
        endcase
        // In READ, r_cnt is the cycle number; the byte on mem_din is r_cnt-2.
        w_bidx    = 2'(r_cnt - 3'd2);
        w_rd_word = r_buf | ({24'b0, mem_din} << {w_bidx, 3'b000});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last_ls <= 1'b0;
            r_cur_ls  <= 1'b0;
            r_addr    <= 32'b0;
            r_wdata   <= 32'b0;
            r_buf     <= 32'b0;
            r_n       <= 3'd0;
            r_cnt     <= 3'd0;
            mem_a     <= 32'b0;
            mem_dout  <= 8'b0;
            mem_wr    <= 1'b0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            if_data   <= 32'b0;
            ls_rdata  <= 32'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_if_v || w_ls_v) begin
                        r_last_ls <= w_pick_ls;
                        r_cur_ls  <= w_pick_ls;
                        r_buf     <= 32'b0;
                        if (w_pick_ls) begin
                            r_addr  <= ls_addr;
                            r_wdata <= ls_wdata;
                            r_n     <= w_ls_n;
                            mem_a   <= ls_addr;
                            if (ls_wr) begin
                                r_state <= ST_WRITE;
                                if (w_grant_stall) begin
                                    mem_wr <= 1'b0;
                                    r_cnt  <= 3'd0;
                                end else begin
                                    mem_wr   <= 1'b1;
                                    mem_dout <= ls_wdata[7:0];
                                    r_cnt    <= 3'd1;
                                end
                            end else begin
                                r_state <= ST_READ;
                                mem_wr  <= 1'b0;
                                r_cnt   <= 3'd1;
                            end
                        end else begin
                            r_addr  <= if_addr;
                            r_n     <= C_FETCH_N;
                            mem_a   <= if_addr;
                            mem_wr  <= 1'b0;
                            r_cnt   <= 3'd1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (!r_cur_ls && flush) begin
                        r_state <= ST_DONE;
                    end else if (r_cnt == r_n + 3'd1) begin
                        r_state <= ST_DONE;
                        if (r_cur_ls) begin
                            ls_done  <= 1'b1;
                            ls_rdata <= w_rd_word;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= w_rd_word;
                        end
                    end else begin
                        if (r_cnt >= 3'd2) begin
                            r_buf <= w_rd_word;
                        end
                        if (r_cnt < r_n) begin
                            mem_a <= r_addr + {29'b0, r_cnt};
                        end
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_WRITE: begin
                    // Here r_cnt counts bytes already issued.
                    if (r_cnt == r_n) begin
                        mem_wr  <= 1'b0;
                        ls_done <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_io_stall) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_a    <= r_addr + {29'b0, r_cnt};
                        mem_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                        r_cnt    <= r_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    mem_a    <= 32'b0;
                    mem_dout <= 8'b0;
                    mem_wr   <= 1'b0;
                    if_done  <= 1'b0;
                    ls_done  <= 1'b0;
                    if_data  <= 32'b0;
                    ls_rdata <= 32'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Randomized bench for mem_arbiter: requesters and a byte RAM are modelled here,
// and a transaction-level schedule predicts every output cycle by cycle.
module tb_mem_arbiter;
    localparam int NCYC = 1600;
    localparam int ASZ  = NCYC + 64;
    localparam int FB   = 4;
    localparam int K_IDLE = 0, K_RADDR = 1, K_RTAIL = 2, K_WR = 3, K_STALL = 4, K_PULSE = 5, K_ABORT = 6;

    logic        clk = 1'b0;
    logic        rst, flush, if_req, ls_req, ls_wr, io_buffer_full;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic        if_done, ls_done, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;

    always #5 clk = ~clk;

    mem_arbiter #(.FETCH_BYTES(FB), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ls_t;

    int n_tests = 0;
    int n_fail  = 0;

    bit          rst_at   [ASZ];
    bit          flush_at [ASZ];
    bit          full_at  [ASZ];
    int          sk       [ASZ];
    logic [31:0] sa       [ASZ];
    logic [31:0] sv       [ASZ];
    bit          sls      [ASZ];
    int          free_cyc;
    bit          last_ls;

    logic [7:0] dmem [int unsigned];
    logic [7:0] mmem [int unsigned];
    logic [31:0] rd_addr;

    logic [31:0] if_q [$];
    ls_t         ls_q [$];
    bit          if_active, ls_active;
    int          if_gap, ls_gap;
    logic [31:0] if_cur;
    ls_t         ls_cur;

    task automatic chk(input string tag, input int cyc, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] dmem_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] mmem_rd(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : init_byte(a);
    endfunction

    function automatic int size_n(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    // Lay out the expected output cycles of one granted transaction.
    task automatic schedule(input int g, input bit is_ls, input logic wr, input logic [31:0] a,
                            input int n, input logic [31:0] wd);
        logic [31:0] word;
        int ab, lastj, cyc, k;
        if (!wr) begin
            word = 32'b0;
            for (int i = 0; i < n; i++) word |= 32'(mmem_rd(a + 32'(i))) << (8 * i);
            ab = 0;
            if (!is_ls)
                for (int j = 1; j <= n + 1; j++) if (ab == 0 && flush_at[g + j]) ab = j;
            lastj = (ab != 0) ? ab : n + 1;
            for (int j = 1; j <= lastj; j++) begin
                sk[g + j] = (j <= n) ? K_RADDR : K_RTAIL;
                sa[g + j] = a + 32'(j - 1);
            end
            if (ab != 0) begin
                sk[g + ab + 1] = K_ABORT;
                free_cyc = g + ab + 2;
            end else begin
                sk[g + n + 2]  = K_PULSE;
                sv[g + n + 2]  = word;
                sls[g + n + 2] = is_ls;
                free_cyc = g + n + 3;
            end
        end else begin
            cyc = g;
            k   = 0;
            while (k < n && cyc < NCYC + 40) begin
                if (a[17:16] == 2'b11 && full_at[cyc]) begin
                    sk[cyc + 1] = K_STALL;
                end else begin
                    sk[cyc + 1] = K_WR;
                    sa[cyc + 1] = a + 32'(k);
                    sv[cyc + 1] = {24'b0, wd[8 * k +: 8]};
                    k++;
                end
                cyc++;
            end
            sk[cyc + 1]  = K_PULSE;
            sv[cyc + 1]  = 32'b0;
            sls[cyc + 1] = 1'b1;
            free_cyc = cyc + 2;
        end
    endtask

    initial begin
        int kind;
        bit v_if, v_ls, pick, if_fin, ls_fin;
        ls_t t;

        for (int i = 0; i < ASZ; i++) begin
            rst_at[i] = 0; flush_at[i] = 0; full_at[i] = 0;
            sk[i] = K_IDLE; sa[i] = 0; sv[i] = 0; sls[i] = 0;
            if (i >= 200 && i < NCYC - 30) begin
                rst_at[i]   = ($urandom_range(0, 399) == 0);
                flush_at[i] = ($urandom_range(0, 24) == 0);
                full_at[i]  = ($urandom_range(0, 2) == 0);
            end
        end
        rst_at[0] = 1; rst_at[1] = 1; rst_at[2] = 1;
        free_cyc = 0;
        last_ls  = 0;
        rd_addr  = 32'b0;

        dmem[32'h100] = 8'h13; dmem[32'h101] = 8'h05; dmem[32'h102] = 8'h10; dmem[32'h103] = 8'h00;
        mmem[32'h100] = 8'h13; mmem[32'h101] = 8'h05; mmem[32'h102] = 8'h10; mmem[32'h103] = 8'h00;
        dmem[32'h3FF] = 8'h80; mmem[32'h3FF] = 8'h80;

        if_q.push_back(32'h100); if_q.push_back(32'h180); if_q.push_back(32'h1C0);
        t = '{1'b1, 2'b10, 32'h200, 32'hAABBCCDD};   ls_q.push_back(t);
        t = '{1'b0, 2'b00, 32'h3FF, 32'h0};          ls_q.push_back(t);
        t = '{1'b1, 2'b01, 32'h0003_0000, 32'h1234}; ls_q.push_back(t);
        t = '{1'b0, 2'b10, 32'h200, 32'h0};          ls_q.push_back(t);
        t = '{1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0};    ls_q.push_back(t);

        if_active = 0; ls_active = 0; if_gap = 0; ls_gap = 0;
        if_cur = 32'b0; ls_cur = '{1'b0, 2'b00, 32'b0, 32'b0};

        for (int c = 0; c < NCYC; c++) begin
            rst = rst_at[c]; flush = flush_at[c]; io_buffer_full = full_at[c];
            if_req = if_active; if_addr = if_cur;
            ls_req = ls_active; ls_wr = ls_cur.wr; ls_size = ls_cur.size;
            ls_addr = ls_cur.addr; ls_wdata = ls_cur.wdata;
            mem_din = dmem_rd(rd_addr);

            kind = (c >= free_cyc) ? K_IDLE : sk[c];
            if_fin = (kind == K_PULSE) && !sls[c];
            ls_fin = (kind == K_PULSE) && sls[c];

            if (c > 0) begin
                @(negedge clk);
                chk("ctl", c, {61'b0, mem_wr, if_done, ls_done}, {61'b0, kind == K_WR, if_fin, ls_fin});
                chk("if_data", c, {32'b0, if_data}, {32'b0, if_fin ? sv[c] : 32'b0});
                chk("ls_rdata", c, {32'b0, ls_rdata}, {32'b0, ls_fin ? sv[c] : 32'b0});
                if (kind == K_IDLE || kind == K_RADDR || kind == K_WR)
                    chk("mem_a", c, {32'b0, mem_a}, {32'b0, (kind == K_IDLE) ? 32'b0 : sa[c]});
                if (kind == K_IDLE || kind == K_WR)
                    chk("mem_dout", c, {56'b0, mem_dout}, {56'b0, (kind == K_IDLE) ? 8'b0 : sv[c][7:0]});
                rd_addr = mem_a;
                if (mem_wr === 1'b1) dmem[mem_a] = mem_dout;
            end

            if (kind == K_WR) mmem[sa[c]] = sv[c][7:0];

            if (rst_at[c]) begin
                free_cyc = c + 1;
                last_ls  = 0;
            end else if (c >= free_cyc) begin
                v_if = if_active && !flush_at[c];
                v_ls = ls_active;
                if (v_if || v_ls) begin
                    pick = v_ls && (!v_if || !last_ls);
                    last_ls = pick;
                    if (pick) begin
                        schedule(c, 1'b1, ls_cur.wr, ls_cur.addr, size_n(ls_cur.size), ls_cur.wdata);
                    end else begin
                        if (if_cur == 32'h180) flush_at[c + 3] = 1;
                        if (if_cur == 32'h1C0) rst_at[c + 2] = 1;
                        schedule(c, 1'b0, 1'b0, if_cur, FB, 32'b0);
                    end
                end
            end

            if (if_active && (rst_at[c] || flush_at[c] || if_fin)) begin
                if_active = 0; if_gap = $urandom_range(1, 3);
            end
            if (ls_active && (rst_at[c] || ls_fin)) begin
                ls_active = 0; ls_gap = $urandom_range(1, 3);
            end
            if (!rst_at[c] && c >= 3 && c < NCYC - 40) begin
                if (!if_active) begin
                    if (if_gap > 0) if_gap--;
                    else begin
                        if (if_q.size() > 0) if_cur = if_q.pop_front();
                        else if ($urandom_range(0, 7) == 0) if_cur = 32'hFFFF_FFFD;
                        else if_cur = 32'h240 + 32'($urandom_range(0, 63));
                        if_active = 1;
                    end
                end
                if (!ls_active) begin
                    if (ls_gap > 0) ls_gap--;
                    else begin
                        if (ls_q.size() > 0) ls_cur = ls_q.pop_front();
                        else begin
                            ls_cur.wr    = $urandom_range(0, 1);
                            ls_cur.size  = 2'($urandom_range(0, 3));
                            ls_cur.wdata = $urandom;
                            case ($urandom_range(0, 9))
                                6, 7:    ls_cur.addr = 32'h0003_0000 + 32'($urandom_range(0, 15));
                                8:       ls_cur.addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                                default: ls_cur.addr = 32'h400 + 32'($urandom_range(0, 63));
                            endcase
                        end
                        ls_active = 1;
                    end
                end
            end

            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
